// File: rtl/fetch_redirect_controller.sv
`default_nettype none
// ============================================================================
// Module  : fetch_redirect_controller
// Purpose : Arbitrates trap/branch/jump PC redirects and sequences the fetch PC.
// Revision: 1.0
// ============================================================================
module fetch_redirect_controller #(
    parameter int XLEN         = 32,
    parameter int NUM_STAGES   = 7,
    parameter int J_FLUSH      = 3,
    parameter int B_FLUSH      = 5,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  hazard_stall_i,
    input  logic                  imem_ready_i,
    input  logic                  jump_req_i,
    input  logic [XLEN-1:0]       jump_target_i,
    input  logic                  branch_req_i,
    input  logic [XLEN-1:0]       branch_target_i,
    input  logic                  trap_req_i,
    input  logic [XLEN-1:0]       trap_vector_i,
    output logic                  pc_stall_o,
    output logic                  pc_load_o,
    output logic [XLEN-1:0]       redirect_target_o,
    output logic [NUM_STAGES-1:0] flush_mask_o,
    output logic                  trap_ack_o,
    output logic [CNT_W-1:0]      redirect_count_o
);

    typedef enum logic [1:0] {S_RUN, S_REDIRECT, S_TRAP_DRAIN} state_e;
    typedef enum logic [1:0] {SRC_NONE, SRC_JUMP, SRC_BRANCH, SRC_TRAP} src_e;

    localparam logic [NUM_STAGES-1:0] J_MASK     = NUM_STAGES'((64'd1 << J_FLUSH) - 64'd1);
    localparam logic [NUM_STAGES-1:0] B_MASK     = NUM_STAGES'((64'd1 << B_FLUSH) - 64'd1);
    localparam logic [3:0]            DRAIN_INIT = 4'(DRAIN_CYCLES);

    state_e            state_q, state_d;
    src_e              src_q, src_d;
    logic [XLEN-1:0]   pend_q, pend_d;
    logic [XLEN-1:0]   last_q;
    logic [3:0]        drain_q, drain_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic                  stall_c;
    logic                  load_c;
    logic                  ack_c;
    logic [NUM_STAGES-1:0] flush_c;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        pend_d  = pend_q;
        drain_d = drain_q;
        count_d = count_q;
        stall_c = 1'b0;
        load_c  = 1'b0;
        ack_c   = 1'b0;
        flush_c = '0;
        case (state_q)
            S_RUN: begin
                stall_c = hazard_stall_i | ~imem_ready_i;
                if (trap_req_i) begin
                    pend_d  = trap_vector_i;
                    src_d   = SRC_TRAP;
                    drain_d = DRAIN_INIT;
                    state_d = S_TRAP_DRAIN;
                end else if (branch_req_i) begin
                    pend_d  = branch_target_i;
                    src_d   = SRC_BRANCH;
                    state_d = S_REDIRECT;
                end else if (jump_req_i) begin
                    pend_d  = jump_target_i;
                    src_d   = SRC_JUMP;
                    state_d = S_REDIRECT;
                end
            end
            S_REDIRECT: begin
                case (src_q)
                    SRC_JUMP:   flush_c = J_MASK;
                    SRC_BRANCH: flush_c = B_MASK;
                    SRC_TRAP:   flush_c = '1;
                    default:    flush_c = '0;
                endcase
                load_c  = imem_ready_i;
                stall_c = ~imem_ready_i;
                if (imem_ready_i) begin
                    if (count_q != '1) begin
                        count_d = count_q + CNT_W'(1);
                    end
                    ack_c   = (src_q == SRC_TRAP);
                    src_d   = SRC_NONE;
                    state_d = S_RUN;
                end else if (trap_req_i && src_q != SRC_TRAP) begin
                    pend_d  = trap_vector_i;
                    src_d   = SRC_TRAP;
                    drain_d = DRAIN_INIT;
                    state_d = S_TRAP_DRAIN;
                end else if (branch_req_i && src_q == SRC_JUMP) begin
                    // Equal/lower priority requests come from the wrong path and are dropped.
                    pend_d  = branch_target_i;
                    src_d   = SRC_BRANCH;
                end
            end
            S_TRAP_DRAIN: begin
                stall_c = 1'b1;
                drain_d = drain_q - 4'd1;
                if (drain_q <= 4'd1) begin
                    state_d = S_REDIRECT;
                end
            end
            default: begin
                state_d = S_RUN;
                src_d   = SRC_NONE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_RUN;
            src_q   <= SRC_NONE;
            pend_q  <= '0;
            last_q  <= '0;
            drain_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            pend_q  <= pend_d;
            drain_q <= drain_d;
            count_q <= count_d;
            if (load_c) begin
                last_q <= pend_q;
            end
        end
    end

    // Combinational outputs are forced low while reset is asserted.
    assign pc_stall_o        = rst_ni & stall_c;
    assign pc_load_o         = rst_ni & load_c;
    assign trap_ack_o        = rst_ni & ack_c;
    assign flush_mask_o      = rst_ni ? flush_c : '0;
    assign redirect_target_o = pc_load_o ? pend_q : last_q;
    assign redirect_count_o  = count_q;

endmodule
`default_nettype wire
